// File: rtl/ex_stage_mdu_if.sv
// Decode-to-execute bundle for ex_stage_mdu: decode fields, ALU/MDU operands,
// pipeline control and the registered EX/MEM fields going out.
interface ex_stage_mdu_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 30,
  parameter int RA_W = 5
);
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   alu_res;
  logic              alu_of;
  logic [2:0]        mdu_op;
  logic [XLEN-1:0]   mdu_a;
  logic [XLEN-1:0]   mdu_b;
  logic              id_en;
  logic [PC_W-1:0]   id_pc;
  logic              id_br_flag;
  logic [1:0]        id_mem_op;
  logic [XLEN-1:0]   id_mem_wdata;
  logic [1:0]        id_ctrl_op;
  logic [RA_W-1:0]   id_dst_addr;
  logic              id_gpr_wen;
  logic [2:0]        id_exp_code;
  logic              ex_en;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_br_flag;
  logic [1:0]        ex_mem_op;
  logic [XLEN-1:0]   ex_mem_wdata;
  logic [1:0]        ex_ctrl_op;
  logic [RA_W-1:0]   ex_dst_addr;
  logic              ex_gpr_wen;
  logic [2:0]        ex_exp_code;
  logic [XLEN-1:0]   ex_out;
  logic              ex_busy;
  logic [XLEN-1:0]   fwd_data;

  modport master (
    output stall, flush, alu_res, alu_of, mdu_op, mdu_a, mdu_b,
           id_en, id_pc, id_br_flag, id_mem_op, id_mem_wdata, id_ctrl_op,
           id_dst_addr, id_gpr_wen, id_exp_code,
    input  ex_en, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wdata, ex_ctrl_op,
           ex_dst_addr, ex_gpr_wen, ex_exp_code, ex_out, ex_busy, fwd_data
  );

  modport slave (
    input  stall, flush, alu_res, alu_of, mdu_op, mdu_a, mdu_b,
           id_en, id_pc, id_br_flag, id_mem_op, id_mem_wdata, id_ctrl_op,
           id_dst_addr, id_gpr_wen, id_exp_code,
    output ex_en, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wdata, ex_ctrl_op,
           ex_dst_addr, ex_gpr_wen, ex_exp_code, ex_out, ex_busy, fwd_data
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: registers single-cycle ALU results into EX/MEM and runs an
// iterative radix-2 multiply/divide unit (shift-add multiply, restoring
// divide) for MUL/MULHU/DIVU/REMU, stalling the pipeline while it iterates.
module ex_stage_mdu #(
  parameter int         XLEN    = 32,
  parameter int         PC_W    = 30,
  parameter int         RA_W    = 5,
  parameter logic [2:0] EXP_OVF = 3'd2
) (
  input logic           cpu_clk,
  input logic           cpu_rst,
  ex_stage_mdu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_REMU  = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic            en;
    logic [PC_W-1:0] pc;
    logic            br;
    logic [1:0]      mem_op;
    logic [XLEN-1:0] wdata;
    logic [1:0]      ctrl;
    logic [RA_W-1:0] dst;
    logic            wen;
    logic [2:0]      exp;
    logic [XLEN-1:0] out;
  } ex_t;

  // Reserved encodings 5-7 behave like "no MDU op".
  function automatic logic is_mdu(input logic [2:0] op);
    return (op != 3'd0) && (op <= OP_REMU);
  endfunction

  // Multiply leaves {hi,lo} in {acc,qr}; divide leaves {rem,quo} in {acc,qr}.
  function automatic logic [XLEN-1:0] mdu_sel(input logic [2:0] op,
                                               input logic [XLEN-1:0] acc,
                                               input logic [XLEN-1:0] qr);
    case (op)
      OP_MUL, OP_DIVU:   return qr;
      OP_MULHU, OP_REMU: return acc;
      default:           return '0;
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_p0;
  logic [XLEN-1:0]  opnd_p0;   // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]  acc_p0;    // product high half / partial remainder
  logic [XLEN-1:0]  qr_p0;     // multiplier-then-product-low / dividend-then-quotient
  ex_t              hld;       // decode fields of the instruction inside the MDU
  ex_t              ex_q;
  ex_t              id_raw;
  ex_t              alu_f;
  logic             start;
  logic             op_is_mul;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_sh;
  logic [XLEN:0]    div_diff;
  logic [XLEN-1:0]  mdu_res;

  // Decode fields as presented, and the single-cycle variant with overflow applied.
  always_comb begin
    id_raw        = '0;
    id_raw.en     = bus.id_en;
    id_raw.pc     = bus.id_pc;
    id_raw.br     = bus.id_br_flag;
    id_raw.mem_op = bus.id_mem_op;
    id_raw.wdata  = bus.id_mem_wdata;
    id_raw.ctrl   = bus.id_ctrl_op;
    id_raw.dst    = bus.id_dst_addr;
    id_raw.wen    = bus.id_gpr_wen;
    id_raw.exp    = bus.id_exp_code;
    id_raw.out    = bus.alu_res;
    alu_f         = id_raw;
    if (bus.alu_of) begin
      alu_f.exp = EXP_OVF;
      alu_f.wen = 1'b0;
    end
  end

  // One radix-2 step of each algorithm; the op register picks which is used.
  always_comb begin
    op_is_mul = (op_p0 == OP_MUL) || (op_p0 == OP_MULHU);
    mul_sum   = {1'b0, acc_p0} + (qr_p0[0] ? {1'b0, opnd_p0} : '0);
    div_sh    = {acc_p0, qr_p0[XLEN-1]};
    div_diff  = div_sh - {1'b0, opnd_p0};
  end

  assign start   = (state == IDLE) && bus.id_en && is_mdu(bus.mdu_op) &&
                   !bus.flush && !bus.stall;
  assign mdu_res = mdu_sel(op_p0, acc_p0, qr_p0);

  assign bus.ex_busy  = !bus.flush && (start || (state == RUN));
  assign bus.fwd_data = (state == DONE) ? mdu_res : bus.alu_res;

  // MDU control FSM and iterative datapath.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_p0   <= '0;
      opnd_p0 <= '0;
      acc_p0  <= '0;
      qr_p0   <= '0;
      hld     <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_p0  <= bus.mdu_op;
            acc_p0 <= '0;
            cnt    <= '0;
            hld    <= id_raw;
            if ((bus.mdu_op == OP_MUL) || (bus.mdu_op == OP_MULHU)) begin
              opnd_p0 <= bus.mdu_a;
              qr_p0   <= bus.mdu_b;
            end else begin
              opnd_p0 <= bus.mdu_b;
              qr_p0   <= bus.mdu_a;
            end
            state <= RUN;
          end
        end
        RUN: begin
          if (op_is_mul) begin
            acc_p0 <= mul_sum[XLEN:1];
            qr_p0  <= {mul_sum[0], qr_p0[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            acc_p0 <= div_diff[XLEN-1:0];
            qr_p0  <= {qr_p0[XLEN-2:0], 1'b1};
          end else begin
            acc_p0 <= div_sh[XLEN-1:0];
            qr_p0  <= {qr_p0[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (!bus.stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register: MDU result, hold, bubble or single-cycle result.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || bus.flush) begin
      ex_q <= '0;
    end else if ((state == DONE) && !bus.stall) begin
      ex_q     <= hld;
      ex_q.out <= mdu_res;
    end else if (bus.stall || (state == DONE)) begin
      ex_q <= ex_q;
    end else if (start || (state == RUN)) begin
      ex_q <= '0;
    end else begin
      ex_q <= alu_f;
    end
  end

  assign bus.ex_en        = ex_q.en;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_br_flag   = ex_q.br;
  assign bus.ex_mem_op    = ex_q.mem_op;
  assign bus.ex_mem_wdata = ex_q.wdata;
  assign bus.ex_ctrl_op   = ex_q.ctrl;
  assign bus.ex_dst_addr  = ex_q.dst;
  assign bus.ex_gpr_wen   = ex_q.wen;
  assign bus.ex_exp_code  = ex_q.exp;
  assign bus.ex_out       = ex_q.out;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: ALU path, MDU arithmetic and latency,
// stall in DONE, flush mid-RUN and reset mid-divide.
module tb_ex_stage_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  ex_stage_mdu_if #(.XLEN(32), .PC_W(30), .RA_W(5)) bus ();

  ex_stage_mdu #(.XLEN(32), .PC_W(30), .RA_W(5), .EXP_OVF(3'd2)) dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.alu_res = '0; bus.alu_of = 0;
    bus.mdu_op = 0; bus.mdu_a = '0; bus.mdu_b = '0;
    bus.id_en = 0; bus.id_pc = '0; bus.id_br_flag = 0; bus.id_mem_op = '0;
    bus.id_mem_wdata = '0; bus.id_ctrl_op = '0; bus.id_dst_addr = '0;
    bus.id_gpr_wen = 0; bus.id_exp_code = '0;
  endtask

  // Issue one MDU op, count busy cycles, optionally stall in DONE, check result.
  task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall_n, input string tag);
    int cnt;
    int guard;
    bus.id_en = 1; bus.mdu_op = op; bus.mdu_a = a; bus.mdu_b = b;
    bus.id_gpr_wen = 1; bus.id_dst_addr = 5'd7; bus.id_pc = 30'h100 + 30'(op);
    bus.alu_res = 32'hDEADBEEF;
    #1 chk({tag, "_busy_start"}, bus.ex_busy, 1);
    tick();
    bus.id_en = 0; bus.mdu_op = 0; bus.mdu_a = '0; bus.mdu_b = '0;
    bus.id_gpr_wen = 0; bus.id_dst_addr = '0; bus.id_pc = '0;
    #1;
    cnt = 1;
    guard = 0;
    while (bus.ex_busy === 1'b1 && guard < 100) begin
      cnt++;
      guard++;
      tick();
    end
    chk({tag, "_busy_cycles"}, cnt, 33);
    chk({tag, "_fwd_done"}, bus.fwd_data, exp);
    if (stall_n > 0) begin
      bus.stall = 1;
      for (int k = 0; k < stall_n; k++) begin
        tick();
        chk({tag, "_stall_en"}, bus.ex_en, 0);
        chk({tag, "_stall_fwd"}, bus.fwd_data, exp);
      end
      bus.stall = 0;
    end
    tick();
    chk({tag, "_out"}, bus.ex_out, exp);
    chk({tag, "_en"}, bus.ex_en, 1);
    chk({tag, "_wen"}, bus.ex_gpr_wen, 1);
    chk({tag, "_dst"}, bus.ex_dst_addr, 7);
    chk({tag, "_pc"}, bus.ex_pc, 30'h100 + 30'(op));
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    chk("rst_en", bus.ex_en, 0);
    chk("rst_out", bus.ex_out, 0);
    chk("rst_wen", bus.ex_gpr_wen, 0);
    chk("rst_pc", bus.ex_pc, 0);
    chk("rst_busy", bus.ex_busy, 0);
    rst = 0;

    // ALU path with overflow
    bus.id_en = 1; bus.alu_res = 32'h1234; bus.alu_of = 1; bus.id_gpr_wen = 1;
    bus.id_exp_code = 0; bus.id_dst_addr = 5'd3; bus.id_pc = 30'h55;
    #1 chk("alu_fwd", bus.fwd_data, 32'h1234);
    chk("alu_busy", bus.ex_busy, 0);
    tick();
    chk("ovf_out", bus.ex_out, 32'h1234);
    chk("ovf_en", bus.ex_en, 1);
    chk("ovf_exp", bus.ex_exp_code, 2);
    chk("ovf_wen", bus.ex_gpr_wen, 0);
    chk("ovf_pc", bus.ex_pc, 30'h55);

    // ALU path without overflow
    bus.alu_of = 0; bus.id_exp_code = 3'd5; bus.alu_res = 32'hCAFE;
    tick();
    chk("alu_out", bus.ex_out, 32'hCAFE);
    chk("alu_exp", bus.ex_exp_code, 5);
    chk("alu_wen", bus.ex_gpr_wen, 1);

    // Stall outside DONE holds the EX register
    bus.stall = 1; bus.alu_res = 32'h9999;
    tick();
    chk("stall_hold", bus.ex_out, 32'hCAFE);
    bus.stall = 0;

    // Reserved MDU op behaves as single-cycle
    bus.mdu_op = 3'd5; bus.alu_res = 32'h77;
    #1 chk("rsv_busy", bus.ex_busy, 0);
    tick();
    chk("rsv_out", bus.ex_out, 32'h77);

    idle_inputs();
    tick();

    run_mdu(3'd1, 32'd7, 32'd6, 32'd42, 0, "mul7x6");
    run_mdu(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_ff");
    run_mdu(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "mul_ff");
    run_mdu(3'd3, 32'd100, 32'd7, 32'd14, 0, "divu100_7");
    run_mdu(3'd4, 32'd100, 32'd7, 32'd2, 3, "remu100_7_stall");
    run_mdu(3'd3, 32'h12345678, 32'd0, 32'hFFFFFFFF, 0, "divu_by0");
    run_mdu(3'd4, 32'd5, 32'd0, 32'd5, 0, "remu_by0");

    // Flush in RUN cycle 10
    bus.id_en = 1; bus.mdu_op = 3'd1; bus.mdu_a = 32'h12345; bus.mdu_b = 32'h10;
    bus.id_gpr_wen = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre_busy", bus.ex_busy, 1);
    bus.flush = 1;
    #1 chk("flush_busy", bus.ex_busy, 0);
    tick();
    bus.flush = 0;
    chk("flush_en", bus.ex_en, 0);
    chk("flush_out", bus.ex_out, 0);
    #1 chk("flush_idle_busy", bus.ex_busy, 0);
    run_mdu(3'd1, 32'd3, 32'd3, 32'd9, 0, "mul3x3");

    // Reset mid-DIVU
    idle_inputs();
    bus.id_en = 1; bus.mdu_op = 3'd3; bus.mdu_a = 32'd1000; bus.mdu_b = 32'd3;
    bus.id_gpr_wen = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_en", bus.ex_en, 0);
    chk("rstmid_out", bus.ex_out, 0);
    chk("rstmid_wen", bus.ex_gpr_wen, 0);
    bus.alu_res = 32'hABCD;
    #1 chk("rstmid_busy", bus.ex_busy, 0);
    chk("rstmid_fwd", bus.fwd_data, 32'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage: registers single-cycle ALU results into the EX/MEM pipeline register and adds an iterative multiply/divide unit (MDU) for multi-cycle operations. Sits between decode (id_*) and memory (ex_*) stages. Raises `ex_busy` to the pipeline controller while an MDU operation is in flight.

## Interface
- XLEN, 32: datapath width (≥8, even)
- PC_W, 30: word-address PC width
- RA_W, 5: register address width
- EXP_OVF, 3'd2: exception code recorded on ALU overflow
- cpu_clk in 1: clock; all state updates on the rising edge
- cpu_rst in 1: reset, synchronous, active-high
- stall in 1: hold EX/MEM register and MDU DONE state
- flush in 1: squash EX contents and abort the MDU
- alu_res in XLEN: result from the external single-cycle ALU
- alu_of in 1: overflow from the external ALU
- mdu_op in 3: 0 none, 1 MUL (low half), 2 MULHU, 3 DIVU, 4 REMU; 5-7 reserved, treated as 0
- mdu_a, mdu_b in XLEN: MDU operands, unsigned
- id_en, id_pc[PC_W], id_br_flag, id_mem_op[2], id_mem_wdata[XLEN], id_ctrl_op[2], id_dst_addr[RA_W], id_gpr_wen, id_exp_code[3] in: decode-stage fields
- ex_en, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wdata, ex_ctrl_op, ex_dst_addr, ex_gpr_wen, ex_exp_code, ex_out[XLEN] out: registered EX/MEM fields
- ex_busy out 1: combinational stall request to the controller
- fwd_data out XLEN: combinational forwarding value

## Operation
- Reset: all ex_* outputs 0; FSM in IDLE; counter and MDU datapath registers 0; `ex_busy` 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start condition: `id_en & mdu_op∈{1..4} & !flush & !stall` is true.
  - On the start edge, latch the operands and op.
  - Clear the counter.
  - Go to RUN.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide).
  - After XLEN steps (counter reaches XLEN-1), go to DONE.
  - `stall` does not pause RUN.
- DONE, `stall` low: the EX register loads the held id_* fields with ex_out = MDU result; go to IDLE.
- DONE, `stall` high: stay in DONE and hold the result.
- A DONE instruction is never restarted, because the controller advances ID in the same cycle.
- `ex_busy` is 1 in the start cycle and throughout RUN; 0 in IDLE (other cases) and DONE.
- Single-cycle path (IDLE, no start, `stall` low):
  - EX register loads the id_* fields with ex_out = `alu_res`.
  - If `alu_of`: ex_exp_code = EXP_OVF, ex_gpr_wen = 0.
- Bubble: in the start cycle and RUN, with `stall` low, the EX register loads ex_en = 0 and ex_gpr_wen = 0. Other fields are don't-care but must be deterministic.
- `stall` high, not in DONE: the EX register holds.
- `flush`: highest priority after reset.
  - The EX register loads all 0.
  - The FSM returns to IDLE from any state.
  - `ex_busy` goes low in the same cycle.
- Arithmetic:
  - MUL returns product[XLEN-1:0].
  - MULHU returns product[2·XLEN-1:XLEN].
  - DIVU/REMU are unsigned.
  - Divide by zero: quotient all ones, remainder = mdu_a, no exception.
- `fwd_data`: MDU result in DONE, otherwise `alu_res`.

## Timing
- Single-cycle op: ex_* valid 1 cycle after the ID cycle.
- MDU op, start cycle T:
  - `ex_busy` high for cycles T..T+XLEN (XLEN+1 cycles).
  - DONE in cycle T+XLEN+1.
  - ex_out valid from T+XLEN+2 (XLEN=32: 34 cycles after T).
- `stall` in DONE adds one cycle per stall cycle; the result is held stable.
- `cpu_rst` mid-RUN: next cycle in IDLE, ex_* = 0, `ex_busy` 0.
- Reset has priority over flush and stall.
- Back-to-back MDU ops: the second can start in the cycle after DONE.

## Test plan
- XLEN=32, MUL 7×6 -> `ex_busy` high 33 cycles; ex_out=42, ex_en=1, ex_gpr_wen as issued.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> ex_out=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Flush in RUN cycle 10 -> `ex_busy` low the same cycle, ex_en=0 next cycle; a new MUL 3×3 then returns 9.
- Stall held 3 cycles in DONE -> ex_out unchanged; result loads on the first cycle with `stall` low.
- ALU path with alu_of=1 -> ex_exp_code=2, ex_gpr_wen=0; `cpu_rst` mid-DIVU -> all ex_* 0 next cycle.
